// File: rtl/cmd_transmitter.sv
// cmd_transmitter: FIFO-buffered command issuer pacing cmd_data with a latch_data pulse.
// Define CMD_TX_COUNT_EN to add the sent_count output.
module cmd_transmitter #(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int GAP_CYCLES    = 2
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [31:0]                   cmd_in,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          flush,
   output logic [31:0]                   cmd_data,
   output logic                          latch_data,
   output logic                          busy,
`ifdef CMD_TX_COUNT_EN
   output logic [15:0]                   sent_count,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [7:0] SETUP_INIT  = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] STROBE_INIT = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] GAP_INIT    = 8'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [31:0]   cmd_data_q, cmd_data_d;
   logic          latch_q, latch_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] level;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic          push, pop;

   assign level     = wr_ptr_q - rd_ptr_q;
   assign cmd_ready = (level != PW'(FIFO_DEPTH));
   // flush beats both the host push and the FSM pop in the same cycle
   assign push      = cmd_valid & cmd_ready & ~flush;
   assign pop       = (state_q == IDLE) & (level != '0) & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + PW'(pop);
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_data_d = cmd_data_q;
      latch_d    = latch_q;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               cmd_data_d = mem_q[rd_ptr_q[AW-1:0]];
               cnt_d      = SETUP_INIT;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               latch_d = 1'b1;
               cnt_d   = STROBE_INIT;
               state_d = STROBE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               latch_d = 1'b0;
               cnt_d   = GAP_INIT;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         GAP: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 8'd1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cmd_data_q <= '0;
         latch_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_data_q <= cmd_data_d;
         latch_q    <= latch_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   assign cmd_data   = cmd_data_q;
   assign latch_data = latch_q;
   assign fifo_level = level;
   assign busy       = (state_q != IDLE) | (level != '0);

`ifdef CMD_TX_COUNT_EN
   logic [15:0] sent_count_q, sent_count_d;

   always_comb begin
      sent_count_d = sent_count_q;
      if (state_q == STROBE && cnt_q == '0) sent_count_d = sent_count_q + 16'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sent_count_q <= '0;
      else          sent_count_q <= sent_count_d;
   end

   assign sent_count = sent_count_q;
`endif

endmodule

// File: tb/tb_cmd_transmitter.sv
// tb_cmd_transmitter: scoreboard bench for cmd_transmitter.
// Two instances: default timing, and SETUP=3 STROBE=1 GAP=4.
module tb_cmd_transmitter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n;
   logic [31:0] cmd_in1, cmd_in2;
   logic        cmd_valid1, cmd_valid2;
   logic        flush1, flush2;
   logic        cmd_ready1, cmd_ready2;
   logic        latch1, latch2;
   logic        busy1, busy2;
   logic [31:0] data1, data2;
   logic [2:0]  level1, level2;
`ifdef CMD_TX_COUNT_EN
   logic [15:0] sent1, sent2;
`endif

   cmd_transmitter u_dut1 (
      .clock(clock), .reset_n(reset_n),
      .cmd_in(cmd_in1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .flush(flush1), .cmd_data(data1), .latch_data(latch1), .busy(busy1),
`ifdef CMD_TX_COUNT_EN
      .sent_count(sent1),
`endif
      .fifo_level(level1)
   );

   cmd_transmitter #(
      .SETUP_CYCLES(3), .STROBE_CYCLES(1), .GAP_CYCLES(4)
   ) u_dut2 (
      .clock(clock), .reset_n(reset_n),
      .cmd_in(cmd_in2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .flush(flush2), .cmd_data(data2), .latch_data(latch2), .busy(busy2),
`ifdef CMD_TX_COUNT_EN
      .sent_count(sent2),
`endif
      .fifo_level(level2)
   );

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] sb1[$];
   logic [31:0] sb2[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // instance 1 monitor: strobe data, width and optional period
   int   cyc = 0, rises1 = 0, last_rise = -1, hi1 = 0;
   logic prev_l1 = 1'b0, mon1 = 1'b0, per_en = 1'b0, full_seen = 1'b0;
   always @(negedge clock) begin
      cyc++;
      if (mon1) begin
         if (latch1 && !prev_l1) begin
            if (sb1.size() == 0) chk("strobe_unexp", 1, 0);
            else chk("strobe_data", data1, sb1.pop_front());
            if (per_en && last_rise >= 0) chk("period", cyc - last_rise, 6);
            rises1++;
            last_rise = cyc;
         end
         if (!latch1 && prev_l1) chk("strobe_len", hi1, 2);
         if (level1 == 3'd4 && !cmd_ready1) full_seen = 1'b1;
      end
      hi1 = latch1 ? hi1 + 1 : 0;
      prev_l1 = latch1;
   end

   // instance 2 monitor: setup / strobe / gap sequence
   int   since2 = 0, hi2 = 0, lo2 = 0, rises2 = 0;
   logic prev_l2 = 1'b0, fell2 = 1'b0;
   logic [31:0] prev_d2 = '0;
   always @(negedge clock) begin
      if (reset_n) begin
         if (data2 !== prev_d2) begin
            if (fell2) chk("t5_gap", 32'(lo2 >= 4), 1);
            if (latch2) chk("t5_chg_high", 1, 0);
            since2 = 0;
         end else begin
            since2++;
         end
         if (latch2 && !prev_l2) begin
            chk("t5_setup", since2, 3);
            if (sb2.size() == 0) chk("t5_unexp", 1, 0);
            else chk("t5_data", data2, sb2.pop_front());
            rises2++;
         end
         if (!latch2 && prev_l2) begin
            chk("t5_strobe", hi2, 1);
            fell2 = 1'b1;
            lo2 = 0;
         end else if (!latch2) begin
            lo2++;
         end
      end
      hi2 = latch2 ? hi2 + 1 : 0;
      prev_l2 = latch2;
      prev_d2 = data2;
   end

   // called at a negedge; returns at the negedge after the push edge
   task automatic push(input int d, input logic [31:0] w, output int stall);
      stall = 0;
      if (d == 1) begin cmd_in1 = w; cmd_valid1 = 1'b1; end
      else        begin cmd_in2 = w; cmd_valid2 = 1'b1; end
      #1;
      while (((d == 1) ? cmd_ready1 : cmd_ready2) == 1'b0 && stall < 50) begin
         stall++;
         @(negedge clock);
         #1;
      end
      if (stall >= 50) chk("push_timeout", 0, 1);
      else if (d == 1) sb1.push_back(w);
      else sb2.push_back(w);
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic sig(input int w);
      case (w)
         0:       return latch1;
         1:       return busy1;
         2:       return latch2;
         default: return busy2;
      endcase
   endfunction

   task automatic wait_for(input int w, input logic v, input string tag);
      int t = 0;
      do begin
         @(negedge clock);
         #1;
         t++;
      end while (sig(w) !== v && t < 200);
      chk(tag, 32'(sig(w)), 32'(v));
   endtask

   int st, r0;

   initial begin
      reset_n = 1'b0;
      cmd_in1 = '0; cmd_in2 = '0;
      cmd_valid1 = 1'b0; cmd_valid2 = 1'b0;
      flush1 = 1'b0; flush2 = 1'b0;
      #1;
      chk("rst_data", data1, 0);
      chk("rst_latch", 32'(latch1), 0);
      chk("rst_ready", 32'(cmd_ready1), 1);
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_level", 32'(level1), 0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      mon1 = 1'b1;

      // 1: single command latency and pulse shape
      push(1, 32'hC400_0000, st);
      chk("t1_edge1_data", data1, 0);
      cmd_valid1 = 1'b0;
      @(negedge clock);
      chk("t1_edge2_data", data1, 32'hC400_0000);
      chk("t1_edge2_latch", 32'(latch1), 0);
      @(negedge clock);
      chk("t1_rise", 32'(latch1), 1);
      @(negedge clock);
      chk("t1_high2", 32'(latch1), 1);
      @(negedge clock);
      chk("t1_fall", 32'(latch1), 0);
      wait_for(1, 1'b0, "t1_busy_low");

      // 2: six back-to-back pushes through a 4-deep FIFO
      @(negedge clock);
      r0 = rises1;
      per_en = 1'b1;
      last_rise = -1;
      full_seen = 1'b0;
      for (int i = 1; i <= 6; i++) push(1, 32'h0001_0000 + 32'(i), st);
      cmd_valid1 = 1'b0;
      wait_for(1, 1'b0, "t2_busy_low");
      chk("t2_issued", rises1 - r0, 6);
      chk("t2_full_stall", 32'(full_seen), 1);
      chk("t2_sb_empty", sb1.size(), 0);
      per_en = 1'b0;

      // 3: flush during the first strobe
      @(negedge clock);
      r0 = rises1;
      for (int i = 0; i < 3; i++) push(1, 32'hF000_0000 + 32'(i), st);
      cmd_valid1 = 1'b0;
      wait_for(0, 1'b1, "t3_in_strobe");
      flush1 = 1'b1;
      sb1.delete();
      @(negedge clock);
      flush1 = 1'b0;
      chk("t3_level", 32'(level1), 0);
      wait_for(1, 1'b0, "t3_busy_low");
      chk("t3_issued", rises1 - r0, 1);
      chk("t3_level_end", 32'(level1), 0);

      // 4: reset mid-strobe
      @(negedge clock);
      push(1, 32'hA5A5_0001, st);
      cmd_valid1 = 1'b0;
      wait_for(0, 1'b1, "t4_in_strobe");
      mon1 = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("t4_latch_async", 32'(latch1), 0);
      chk("t4_data_async", data1, 0);
      @(negedge clock);
      reset_n = 1'b1;
      sb1.delete();
      @(negedge clock);
      #1;
      chk("t4_busy", 32'(busy1), 0);
      chk("t4_level", 32'(level1), 0);
      chk("t4_data_hold", data1, 0);
      mon1 = 1'b1;

      // 5: long setup, short strobe, long gap
      @(negedge clock);
      push(2, 32'h1111_1111, st);
      push(2, 32'h2222_2222, st);
      push(2, 32'h3333_3333, st);
      cmd_valid2 = 1'b0;
      wait_for(3, 1'b0, "t5_busy_low");
      chk("t5_issued", rises2, 3);
      chk("t5_sb_empty", sb2.size(), 0);

`ifdef CMD_TX_COUNT_EN
      // 6: sent_count wrap
      @(negedge clock);
      force u_dut1.sent_count_q = 16'hFFFE;
      @(negedge clock);
      release u_dut1.sent_count_q;
      @(negedge clock);
      chk("t6_preload", 32'(sent1), 32'hFFFE);
      for (int i = 0; i < 3; i++) push(1, 32'hBEEF_0000 + 32'(i), st);
      cmd_valid1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         logic [15:0] e;
         e = 16'hFFFF + 16'(k);
         if (k > 0) wait_for(0, 1'b1, "t6_rise");
         wait_for(0, 1'b0, "t6_fall");
         chk("t6_count", 32'(sent1), 32'(e));
      end
      wait_for(1, 1'b0, "t6_busy_low");
`endif

      repeat (2) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
